uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DBITS, default 8, data word width.
REQ-003 SHALL have parameter TAG_EN, default 1, 1 = prefix each packet with a channel tag word.
REQ-004 SHALL have parameter TAG_BASE, default 8'hF0, tag value is TAG_BASE OR requester index.
REQ-005 SHALL have parameter MAX_LEN, default 16, maximum data words per grant (1..255).
REQ-006 SHALL have port clk_100MHz  input  1  system clock, all logic on rising edge.
REQ-007 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port req_valid  input  NREQ  per-requester word available.
REQ-009 SHALL have port req_data  input  NREQ*DBITS  requester i word at bits [i*DBITS +: DBITS].
REQ-010 SHALL have port req_last  input  NREQ  per-requester final word of packet, qualified by req_valid.
REQ-011 SHALL have port req_ready  output  NREQ  per-requester word accepted this cycle.
REQ-012 SHALL have port tx_start  output  1  one-cycle start pulse to UART transmitter.
REQ-013 SHALL have port tx_data  output  DBITS  word to transmitter, valid while tx_start is high.
REQ-014 SHALL have port tx_done  input  1  transmitter end-of-word pulse.
REQ-015 SHALL have port grant  output  NREQ  one-hot current owner, all-zero when idle.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, TAG, TAG_WAIT, DATA, DATA_WAIT.
REQ-018 IDLE: when any req_valid is high, SHALL select a winner by round-robin, searching from index (last_owner+1) mod NREQ upward with wrap; SHALL register grant and go to TAG if TAG_EN=1, else DATA.
REQ-019 IDLE with no req_valid SHALL stay in IDLE, grant=0.
REQ-020 TAG: SHALL assert tx_start for exactly one cycle with tx_data = TAG_BASE | index, then go to TAG_WAIT.
REQ-021 TAG_WAIT: on tx_done SHALL go to DATA; otherwise hold.
REQ-022 DATA: if req_valid of owner is high, SHALL assert tx_start and req_ready of owner in the same cycle, drive tx_data = owner req_data, capture req_last, increment the word count, and go to DATA_WAIT.
REQ-023 DATA with owner req_valid low SHALL hold grant and wait indefinitely, no tx_start.
REQ-024 DATA_WAIT: on tx_done SHALL go to IDLE if the captured last is set or word count equals MAX_LEN, else DATA.
REQ-025 On return to IDLE SHALL set last_owner to the releasing index, clear grant and the word count.
REQ-026 req_ready SHALL be high only for the owner and only in the DATA accept cycle; non-owners SHALL see req_ready=0.
REQ-027 tx_start SHALL never be asserted in the cycle tx_done is high; the first tx_start after tx_done SHALL be no earlier than the following cycle.
REQ-028 tx_done outside TAG_WAIT/DATA_WAIT SHALL be ignored.
REQ-029 Word count SHALL be 8 bits, never wrap; reaching MAX_LEN SHALL force release even when req_last is low, and the remaining words SHALL wait for a new grant (a new tag is sent if TAG_EN=1).
REQ-030 Changes on req_valid/req_data of non-owners SHALL not affect the current grant.
REQ-031 tx_data SHALL be zero whenever tx_start is low.

Reset
REQ-032 While reset_n is low SHALL force state IDLE, grant=0, req_ready=0, tx_start=0, tx_data=0, busy=0, word count 0, last_owner=NREQ-1 (requester 0 wins first).
REQ-033 Reset asserted mid-packet SHALL abort immediately with no further tx_start; the transmitter reset is handled outside this block.
REQ-034 After reset_n deasserts, the first arbitration SHALL occur on the first rising edge with reset_n high.

Verification
REQ-035 Single requester: req 2 sends 3 words 0x11,0x22,0x33 (last on 0x33), TAG_EN=1 -> tx_start sequence 0xF2,0x11,0x22,0x33, each after previous tx_done, then IDLE, grant=0.
REQ-036 Round-robin: reqs 0,1,3 all valid with 1-word packets after reset -> tags 0xF0,0xF1,0xF3 in that order; repeat -> 0xF0 again after 0xF3 (wrap).
REQ-037 MAX_LEN=2, req 1 sends 5 words no last, req 2 idle -> 0xF1,w0,w1,0xF1,w2,w3,0xF1,w4 ... release after every 2 words.
REQ-038 Stall: owner drops req_valid for 50 cycles mid-packet -> no tx_start, grant held, busy=1; resumes on req_valid.
REQ-039 Reset mid-packet: reset_n low during DATA_WAIT -> next cycle all outputs 0; after release with req 0 and req 3 valid, req 0 granted.
REQ-040 Protocol checker: tx_start never high outside TAG/DATA, never two tx_start without intervening tx_done, grant always one-hot or zero.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding tagged packets from NREQ requesters into one UART transmitter
// Ports: clk_100MHz/reset_n clock and async active-low reset; req_valid/req_data/req_last/req_ready
// per-requester word handshake; tx_start/tx_data/tx_done transmitter handshake; grant one-hot owner; busy not idle.
module uart_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int DBITS = 8,
  parameter int TAG_EN = 1,
  parameter logic [7:0] TAG_BASE = 8'hF0,
  parameter int MAX_LEN = 16
) (
  input  logic                    clk_100MHz,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DBITS-1:0]   req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic                    tx_start,
  output logic [DBITS-1:0]        tx_data,
  input  logic                    tx_done,
  output logic [NREQ-1:0]         grant,
  output logic                    busy
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [2:0] {IDLE, TAG, TAG_WAIT, DATA, DATA_WAIT} state_t;
  state_t state;
  logic [IW-1:0] owner, last_owner, winner, idx;
  logic [7:0] cnt;
  logic found, last_q, owner_valid, accept;
  logic [DBITS-1:0] owner_data, tag_word;
  always_comb begin
    winner = last_owner;
    found = 1'b0;
    idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last_owner) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        winner = idx;
      end
    end
  end
  assign owner_valid = req_valid[owner];
  assign owner_data = req_data[owner*DBITS +: DBITS];
  assign tag_word = DBITS'(TAG_BASE) | DBITS'(owner);
  // The data word must be accepted in the same cycle the owner presents it,
  // so the transmitter strobes are decoded from the registered state rather than registered themselves.
  assign accept = state == DATA && owner_valid;
  assign tx_start = state == TAG || accept;
  assign tx_data = state == TAG ? tag_word : accept ? owner_data : '0;
  assign req_ready = accept ? grant : '0;
  assign busy = state != IDLE;
  always_ff @(posedge clk_100MHz or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      grant <= '0;
      owner <= '0;
      last_owner <= IW'(NREQ - 1);
      cnt <= '0;
      last_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          owner <= winner;
          grant <= NREQ'(1) << winner;
          state <= TAG_EN != 0 ? TAG : DATA;
        end
        TAG: state <= TAG_WAIT;
        TAG_WAIT: if (tx_done) state <= DATA;
        DATA: if (owner_valid) begin
          last_q <= req_last[owner];
          cnt <= cnt + 8'd1;
          state <= DATA_WAIT;
        end
        DATA_WAIT: if (tx_done) begin
          if (last_q || cnt == 8'(MAX_LEN)) begin
            state <= IDLE;
            last_owner <= owner;
            grant <= '0;
            cnt <= '0;
          end else state <= DATA;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter (dut_a MAX_LEN=16, dut_b MAX_LEN=2)
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic clk_100MHz = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;
  logic [N-1:0] req_valid_a = '0, req_last_a = '0, req_ready_a, grant_a;
  logic [N-1:0] req_valid_b = '0, req_last_b = '0, req_ready_b, grant_b;
  logic [N*W-1:0] req_data_a = '0, req_data_b = '0;
  logic [W-1:0] tx_data_a, tx_data_b, e_a, e_b;
  logic tx_start_a, tx_start_b, busy_a, busy_b;
  logic tx_done_a = 1'b0, tx_done_b = 1'b0;
  logic [8:0] src_a[N][$];
  logic [8:0] src_b[N][$];
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [N-1:0] hold = '0, acc_a = '0, acc_b = '0;
  logic [2:0] tc_a = '0, tc_b = '0;
  bit pend_a, pend_b, out_a, out_b;
  int errors = 0, checks = 0;

  uart_tx_arbiter #(.NREQ(N), .DBITS(W), .TAG_EN(1), .TAG_BASE(8'hF0), .MAX_LEN(16)) dut_a (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .req_valid(req_valid_a), .req_data(req_data_a),
    .req_last(req_last_a), .req_ready(req_ready_a), .tx_start(tx_start_a), .tx_data(tx_data_a),
    .tx_done(tx_done_a), .grant(grant_a), .busy(busy_a));
  uart_tx_arbiter #(.NREQ(N), .DBITS(W), .TAG_EN(1), .TAG_BASE(8'hF0), .MAX_LEN(2)) dut_b (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .req_valid(req_valid_b), .req_data(req_data_b),
    .req_last(req_last_b), .req_ready(req_ready_b), .tx_start(tx_start_b), .tx_data(tx_data_b),
    .tx_done(tx_done_b), .grant(grant_b), .busy(busy_b));

  // requester models: present the head of each source queue, pop it once accepted
  always @(posedge clk_100MHz) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_a[i] && src_a[i].size() > 0) void'(src_a[i].pop_front());
      if (acc_b[i] && src_b[i].size() > 0) void'(src_b[i].pop_front());
      req_valid_a[i] = src_a[i].size() > 0 && !hold[i];
      {req_last_a[i], req_data_a[i*W +: W]} = src_a[i].size() > 0 ? src_a[i][0] : 9'h0;
      req_valid_b[i] = src_b[i].size() > 0;
      {req_last_b[i], req_data_b[i*W +: W]} = src_b[i].size() > 0 ? src_b[i][0] : 9'h0;
    end
  end

  // transmitter models: tx_done pulse a few cycles after each tx_start
  always @(posedge clk_100MHz or negedge reset_n)
    if (!reset_n) begin
      pend_a <= 1'b0; tc_a <= '0; tx_done_a <= 1'b0;
      pend_b <= 1'b0; tc_b <= '0; tx_done_b <= 1'b0;
    end else begin
      tx_done_a <= 1'b0;
      if (tx_start_a) begin pend_a <= 1'b1; tc_a <= 3'd3; end
      else if (pend_a) begin if (tc_a == 0) begin tx_done_a <= 1'b1; pend_a <= 1'b0; end else tc_a <= tc_a - 3'd1; end
      tx_done_b <= 1'b0;
      if (tx_start_b) begin pend_b <= 1'b1; tc_b <= 3'd2; end
      else if (pend_b) begin if (tc_b == 0) begin tx_done_b <= 1'b1; pend_b <= 1'b0; end else tc_b <= tc_b - 3'd1; end
    end

  // scoreboard pop and protocol checks on both instances
  always @(negedge clk_100MHz) begin
    acc_a = req_ready_a & req_valid_a;
    acc_b = req_ready_b & req_valid_b;
    if (!reset_n) begin
      out_a = 1'b0; out_b = 1'b0; acc_a = '0; acc_b = '0;
    end else begin
      if (tx_start_a) begin
        checks++;
        if (exp_a.size() == 0) begin errors++; $display("FAIL word_a got=%h required=no tx_start", tx_data_a); end
        else begin e_a = exp_a.pop_front(); if (tx_data_a !== e_a) begin errors++; $display("FAIL word_a got=%h required=%h", tx_data_a, e_a); end end
      end
      if (tx_start_b) begin
        checks++;
        if (exp_b.size() == 0) begin errors++; $display("FAIL word_b got=%h required=no tx_start", tx_data_b); end
        else begin e_b = exp_b.pop_front(); if (tx_data_b !== e_b) begin errors++; $display("FAIL word_b got=%h required=%h", tx_data_b, e_b); end end
      end
      checks++;
      if ((tx_start_a && (tx_done_a || out_a)) || (!tx_start_a && tx_data_a !== '0) || !$onehot0(grant_a)) begin
        errors++; $display("FAIL proto_a start=%0d done=%0d outstanding=%0d data=%h grant=%b required legal handshake", tx_start_a, tx_done_a, out_a, tx_data_a, grant_a);
      end
      checks++;
      if ((tx_start_b && (tx_done_b || out_b)) || (!tx_start_b && tx_data_b !== '0) || !$onehot0(grant_b)) begin
        errors++; $display("FAIL proto_b start=%0d done=%0d outstanding=%0d data=%h grant=%b required legal handshake", tx_start_b, tx_done_b, out_b, tx_data_b, grant_b);
      end
      if (tx_start_a) out_a = 1'b1; else if (tx_done_a) out_a = 1'b0;
      if (tx_start_b) out_b = 1'b1; else if (tx_done_b) out_b = 1'b0;
    end
  end

  task automatic wait_idle(input bit sel, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk_100MHz); #1;
      ok = sel ? (exp_b.size() == 0 && !busy_b) : (exp_a.size() == 0 && !busy_a);
    end
  endtask

  task automatic wait_exp_a(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk_100MHz); #1;
      ok = exp_a.size() <= n;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_100MHz);
    checks++; if (grant_a !== '0) begin errors++; $display("FAIL reset_grant got=%b required=0000", grant_a); end
    checks++; if (req_ready_a !== '0) begin errors++; $display("FAIL reset_ready got=%b required=0000", req_ready_a); end
    checks++; if (tx_start_a !== 1'b0) begin errors++; $display("FAIL reset_start got=%b required=0", tx_start_a); end
    checks++; if (tx_data_a !== '0) begin errors++; $display("FAIL reset_data got=%h required=00", tx_data_a); end
    checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b%b required=00", busy_a, busy_b); end
    reset_n = 1'b1;
  endtask

  task automatic test_round_robin();
    bit ok;
    for (int r = 0; r < 2; r++) begin
      src_a[0].push_back({1'b1, 8'hA0}); src_a[1].push_back({1'b1, 8'hA1}); src_a[3].push_back({1'b1, 8'hA3});
      exp_a.push_back(8'hF0); exp_a.push_back(8'hA0);
      exp_a.push_back(8'hF1); exp_a.push_back(8'hA1);
      exp_a.push_back(8'hF3); exp_a.push_back(8'hA3);
      wait_idle(1'b0, 300, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rr_done round=%0d left=%0d busy=%b required drained idle", r, exp_a.size(), busy_a); end
    end
    checks++; if (grant_a !== '0) begin errors++; $display("FAIL rr_grant got=%b required=0000", grant_a); end
  endtask

  task automatic test_single();
    bit ok;
    src_a[2].push_back({1'b0, 8'h11}); src_a[2].push_back({1'b0, 8'h22}); src_a[2].push_back({1'b1, 8'h33});
    exp_a.push_back(8'hF2); exp_a.push_back(8'h11); exp_a.push_back(8'h22); exp_a.push_back(8'h33);
    wait_idle(1'b0, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_done left=%0d busy=%b required drained idle", exp_a.size(), busy_a); end
    checks++; if (grant_a !== '0 || busy_a !== 1'b0) begin errors++; $display("FAIL single_idle grant=%b busy=%b required 0000/0", grant_a, busy_a); end
  endtask

  task automatic test_stall();
    bit ok;
    src_a[0].push_back({1'b0, 8'h51}); src_a[0].push_back({1'b0, 8'h52}); src_a[0].push_back({1'b1, 8'h53});
    exp_a.push_back(8'hF0); exp_a.push_back(8'h51); exp_a.push_back(8'h52); exp_a.push_back(8'h53);
    wait_exp_a(2, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_first left=%0d required<=2", exp_a.size()); end
    hold[0] = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_100MHz); #1;
      checks++;
      if (tx_start_a !== 1'b0 || grant_a !== 4'b0001 || busy_a !== 1'b1 || exp_a.size() != 2) begin
        errors++; $display("FAIL stall_hold cyc=%0d start=%b grant=%b busy=%b left=%0d required 0/0001/1/2", i, tx_start_a, grant_a, busy_a, exp_a.size());
      end
    end
    hold[0] = 1'b0;
    wait_idle(1'b0, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_resume left=%0d busy=%b required drained idle", exp_a.size(), busy_a); end
  endtask

  task automatic test_max_len();
    bit ok;
    for (int i = 0; i < 6; i++) src_b[1].push_back({i == 5, 8'hB0 + 8'(i)});
    exp_b = '{8'hF1, 8'hB0, 8'hB1, 8'hF1, 8'hB2, 8'hB3, 8'hF1, 8'hB4, 8'hB5};
    wait_idle(1'b1, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL maxlen_done left=%0d busy=%b required drained idle", exp_b.size(), busy_b); end
    checks++; if (grant_b !== '0) begin errors++; $display("FAIL maxlen_grant got=%b required=0000", grant_b); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    src_a[1].push_back({1'b0, 8'hC1}); src_a[1].push_back({1'b0, 8'hC2}); src_a[1].push_back({1'b1, 8'hC3});
    exp_a.push_back(8'hF1); exp_a.push_back(8'hC1); exp_a.push_back(8'hC2); exp_a.push_back(8'hC3);
    wait_exp_a(2, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_first left=%0d required<=2", exp_a.size()); end
    @(posedge clk_100MHz); #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (tx_start_a !== 1'b0 || grant_a !== '0 || busy_a !== 1'b0 || req_ready_a !== '0 || tx_data_a !== '0) begin
      errors++; $display("FAIL rstmid_async start=%b grant=%b busy=%b ready=%b data=%h required all 0", tx_start_a, grant_a, busy_a, req_ready_a, tx_data_a);
    end
    exp_a.delete();
    for (int i = 0; i < N; i++) src_a[i].delete();
    @(negedge clk_100MHz);
    checks++;
    if (tx_start_a !== 1'b0 || grant_a !== '0 || busy_a !== 1'b0 || tx_data_a !== '0) begin
      errors++; $display("FAIL rstmid_next start=%b grant=%b busy=%b data=%h required all 0", tx_start_a, grant_a, busy_a, tx_data_a);
    end
    src_a[0].push_back({1'b1, 8'hD0}); src_a[3].push_back({1'b1, 8'hD3});
    exp_a.push_back(8'hF0); exp_a.push_back(8'hD0); exp_a.push_back(8'hF3); exp_a.push_back(8'hD3);
    repeat (2) @(negedge clk_100MHz);
    reset_n = 1'b1;
    @(negedge clk_100MHz); #1;
    checks++; if (grant_a !== 4'b0001) begin errors++; $display("FAIL rstmid_grant got=%b required=0001", grant_a); end
    wait_idle(1'b0, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_done left=%0d busy=%b required drained idle", exp_a.size(), busy_a); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_stall();
    test_max_len();
    test_reset_mid();
    repeat (5) @(negedge clk_100MHz);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
